// File: rtl/strng_pkg.sv
// Shared constants for the TRNG UART streaming path.
// Holds the FSM state encoding and the UART frame geometry.
package strng_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/rnd_rct_monitor.sv
// Repetition-count health test on sampled random bytes.
// Flags a stuck source after RCT_CUTOFF identical consecutive captures.
module rnd_rct_monitor #(
    parameter int RCT_CUTOFF = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sample,
    input  logic [7:0] sample_byte,
    input  logic       rct_clr,
    output logic       pass,
    output logic       rct_fail
);

    localparam logic [7:0] CUTOFF = 8'(RCT_CUTOFF);

    logic [7:0] prev_byte;
    logic [7:0] rep_cnt;
    logic [7:0] rep_nxt;

    // Run length the current byte would produce if it were captured now.
    always_comb begin
        rep_nxt = rep_cnt;
        if (rep_cnt == 8'd0 || sample_byte != prev_byte)
            rep_nxt = 8'd1;
        else if (rep_cnt < CUTOFF)
            rep_nxt = rep_cnt + 8'd1;
        pass = (rep_nxt < CUTOFF);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_byte <= 8'd0;
            rep_cnt   <= 8'd0;
            rct_fail  <= 1'b0;
        end else if (rct_clr) begin
            rep_cnt  <= 8'd0;
            rct_fail <= 1'b0;
        end else if (sample) begin
            rep_cnt   <= rep_nxt;
            prev_byte <= sample_byte;
            if (!pass)
                rct_fail <= 1'b1;
        end
    end

endmodule

// File: rtl/rnd_uart_tx.sv
// Streams health-tested TRNG bytes out as 8N1 UART frames, LSB first.
// One capture per frame; a failing byte is dropped and streaming halts until rct_clr.
module rnd_uart_tx
    import strng_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int RCT_CUTOFF = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rnd_data,
    input  logic        en,
    input  logic        rct_clr,
    output logic        uart_tx,
    output logic        busy,
    output logic        rct_fail,
    output logic [15:0] byte_cnt
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          capture;
    logic          pass;
    logic          bit_end;

    // rct_clr wins over capture in the same cycle.
    assign capture = (state == ST_IDLE) && en && !rct_fail && !rct_clr;
    assign bit_end = (baud_cnt == BAUD_LAST);

    rnd_rct_monitor #(
        .RCT_CUTOFF (RCT_CUTOFF)
    ) u_rct (
        .clk         (clk),
        .rstn        (rstn),
        .sample      (capture),
        .sample_byte (rnd_data),
        .rct_clr     (rct_clr),
        .pass        (pass),
        .rct_fail    (rct_fail)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            byte_cnt <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= 3'd0;
                    if (capture) begin
                        shift <= rnd_data;
                        if (pass)
                            state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT)
                            state <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        byte_cnt <= byte_cnt + 16'd1;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Decoded from state so an asynchronous reset idles the line at once.
    always_comb begin
        uart_tx = 1'b1;
        case (state)
            ST_START: uart_tx = 1'b0;
            ST_DATA:  uart_tx = shift[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_rnd_uart_tx.sv
// Directed bench for rnd_uart_tx at CLKS_PER_BIT=4, RCT_CUTOFF=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rnd_uart_tx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rnd_data = 8'd0;
    logic        en = 1'b0;
    logic        rct_clr = 1'b0;
    logic        uart_tx;
    logic        busy;
    logic        rct_fail;
    logic [15:0] byte_cnt;

    int n_cmp = 0;
    int n_err = 0;

    rnd_uart_tx #(
        .CLK_FREQ   (1000),
        .BAUD       (250),
        .RCT_CUTOFF (3)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rnd_data (rnd_data),
        .en       (en),
        .rct_clr  (rct_clr),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .rct_fail (rct_fail),
        .byte_cnt (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks 40 cycles of a frame starting at the current (first START) cycle,
    // ending on the IDLE cycle that follows the stop bit.
    task automatic check_frame(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("frame%02h_tx_%0d", b, i), {31'd0, uart_tx}, {31'd0, frame[i/4]});
            chk($sformatf("frame%02h_busy_%0d", b, i), {31'd0, busy}, 32'd1);
            tick();
        end
        chk("frame_end_busy", {31'd0, busy}, 32'd0);
        chk("frame_end_tx", {31'd0, uart_tx}, 32'd1);
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fail", {31'd0, rct_fail}, 32'd0);
        chk("rst_cnt", {16'd0, byte_cnt}, 32'd0);
        rstn = 1'b1;
        tick();

        // Basic frame, en pulsed for one cycle
        rnd_data = 8'hA5;
        en = 1'b1;
        tick();
        en = 1'b0;
        check_frame(8'hA5);
        chk("basic_cnt", {16'd0, byte_cnt}, 32'd1);
        tick();
        chk("basic_no_refire", {31'd0, busy}, 32'd0);

        // Continuous stream, alternating data, 41-cycle spacing
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            chk($sformatf("stream_idle_%0d", f), {31'd0, busy}, 32'd0);
            rnd_data = (f % 2 == 0) ? 8'h3C : 8'hC3;
            tick();
            check_frame(rnd_data);
        end
        chk("stream_cnt", {16'd0, byte_cnt}, 32'd5);
        chk("stream_fail", {31'd0, rct_fail}, 32'd0);
        en = 1'b0;

        // RCT trip: constant 0x00 gives exactly two frames
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        rnd_data = 8'h00;
        en = 1'b1;
        tick();
        check_frame(8'h00);
        tick();
        check_frame(8'h00);
        tick();
        chk("trip_fail", {31'd0, rct_fail}, 32'd1);
        chk("trip_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("trip_idle_tx_%0d", i), {31'd0, uart_tx}, 32'd1);
            tick();
        end
        chk("trip_cnt", {16'd0, byte_cnt}, 32'd2);
        chk("trip_busy_late", {31'd0, busy}, 32'd0);

        // RCT clear with en high: no capture in the clear cycle
        rct_clr = 1'b1;
        tick();
        rct_clr = 1'b0;
        chk("clr_fail", {31'd0, rct_fail}, 32'd0);
        chk("clr_no_capture", {31'd0, busy}, 32'd0);
        tick();
        check_frame(8'h00);
        tick();
        check_frame(8'h00);
        tick();
        chk("retrip_fail", {31'd0, rct_fail}, 32'd1);
        chk("retrip_busy", {31'd0, busy}, 32'd0);
        chk("retrip_cnt", {16'd0, byte_cnt}, 32'd4);

        // Reset mid-frame during DATA bit 3
        en = 1'b0;
        rct_clr = 1'b1;
        tick();
        rct_clr = 1'b0;
        rnd_data = 8'hA5;
        en = 1'b1;
        tick();
        chk("mid_start_tx", {31'd0, uart_tx}, 32'd0);
        repeat (17) tick();
        chk("mid_bit3_tx", {31'd0, uart_tx}, 32'd0);
        chk("mid_cnt_before", {16'd0, byte_cnt}, 32'd4);
        #1 rstn = 1'b0;
        #1;
        chk("async_tx", {31'd0, uart_tx}, 32'd1);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_cnt", {16'd0, byte_cnt}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        check_frame(8'hA5);
        chk("post_rst_cnt", {16'd0, byte_cnt}, 32'd1);
        en = 1'b0;

        // byte_cnt wrap from 0xFFFF
        tick();
        force dut.byte_cnt = 16'hFFFF;
        #1 release dut.byte_cnt;
        tick();
        rnd_data = 8'h5A;
        en = 1'b1;
        tick();
        en = 1'b0;
        check_frame(8'h5A);
        chk("wrap_cnt", {16'd0, byte_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rnd_uart_tx.md
Name: rnd_uart_tx

Overview:
- Downstream consumer of the TRNG byte output (`strng_core` `rnd_data[7:0]`).
- Samples a random byte, applies a repetition-count health test, and serializes passing bytes on a UART line (8N1, LSB first) to the board header.
- Lets random output be captured by a host PC instead of only being probed on port A pins.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD, integer division; 434 at defaults.
- RCT_CUTOFF, 8, number of consecutive identical sampled bytes that trips the health test. Legal range 2..255.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- rnd_data  input  8  random byte from the TRNG; always valid, sampled only at capture.
- en  input  1  streaming enable, level-sensitive.
- rct_clr  input  1  single-cycle pulse; clears the health-test failure and the repetition counter.
- uart_tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress (START, DATA, STOP).
- rct_fail  output  1  sticky health-test failure flag.
- byte_cnt  output  16  count of completed frames.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rstn` is asynchronous and active-low.
- Reset values: uart_tx=1, busy=0, rct_fail=0, byte_cnt=0, state=IDLE, baud counter=0, bit index=0, prev_byte=0, rep_cnt=0.
  - Assertion mid-frame forces uart_tx high immediately (asynchronous).
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Capture happens on a cycle with en=1, rct_fail=0 and rct_clr=0.
  - On capture, latch rnd_data into the shift register and run the health test (below).
  - If the test passes, go to START on the next cycle with busy=1. Otherwise stay in IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 in START, DATA and STOP. Each bit lasts exactly CLKS_PER_BIT cycles.
- START: uart_tx=0 for one bit time, then go to DATA.
- DATA: uart_tx = shift[0]. Shift right at each bit end. After bit index 7, go to STOP.
- STOP: uart_tx=1 for one bit time. At its last cycle:
  - byte_cnt increments, wrapping 0xFFFF to 0x0000.
  - Next state is IDLE; busy drops on entering IDLE.
- Throughput: capture-to-capture period with en held high is 10*CLKS_PER_BIT+1 cycles.
- en deasserted mid-frame: the current frame completes; no new capture follows.
- Health test (repetition count), evaluated at capture:
  - If rep_cnt==0 or the byte differs from prev_byte, rep_cnt=1. Otherwise rep_cnt=rep_cnt+1.
  - prev_byte is then updated to the captured byte.
  - If the new rep_cnt reaches RCT_CUTOFF, set rct_fail. That byte is discarded (no frame) and the FSM stays in IDLE.
- rct_fail is sticky until rct_clr or reset.
- rct_clr:
  - Clears rct_fail and rep_cnt to 0. prev_byte is unchanged.
  - Has priority over capture in the same cycle.
  - Asserted mid-frame, it does not disturb the frame.
- rep_cnt width is 8 bits and saturates at RCT_CUTOFF.
- Latency: capture to start-bit falling edge on uart_tx is 1 cycle.

Decomposition:
- Shared package `strng_pkg` holds:
  - FSM state encoding: 2-bit localparams ST_IDLE, ST_START, ST_DATA, ST_STOP.
  - UART_DATA_BITS=8.
  - UART_FRAME_BITS=10.
- One natural sub-module, `rnd_rct_monitor`.
  - Inputs: clk, rstn, sample strobe, byte, rct_clr.
  - Outputs: pass and rct_fail.
  - Contains prev_byte, rep_cnt and the sticky flag.
- The baud counter and FSM remain in `rnd_uart_tx`.

Test Plan:
All scenarios use CLK_FREQ=1000, BAUD=250, giving CLKS_PER_BIT=4.
- Basic frame: rnd_data=0xA5, en pulsed high 1 cycle → uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high 40 cycles; byte_cnt=1.
- Continuous stream: en held high, rnd_data alternating 0x3C/0xC3 per frame → frames back-to-back with start edges 41 cycles apart; after 5 frames byte_cnt=5, rct_fail=0.
- RCT trip with RCT_CUTOFF=3: rnd_data fixed 0x00, en high → exactly 2 frames sent; rct_fail=1 at the 3rd capture; uart_tx then stays 1; byte_cnt=2.
- RCT clear: after the trip, pulse rct_clr with data still 0x00 → 2 more frames, then rct_fail=1 again; with rct_clr and en both high in one cycle, no capture occurs that cycle.
- Reset mid-frame: rstn low during DATA bit 3 → uart_tx=1, busy=0, byte_cnt=0 asynchronously. After release with en high, a full frame starts 1 cycle after the first capture.
- Wrap: preload or force byte_cnt=0xFFFF, send one frame → byte_cnt=0x0000.
